// File: rtl/approx_eval_pkg.sv
// Shared types and width helpers for the approximate-adder error evaluation slice.
package approx_eval_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Signed error of a (WIDTH+1)-bit sum against a (WIDTH+1)-bit exact sum.
  function automatic int err_width(input int width);
    return width + 2;
  endfunction

  // Squared-error accumulator: max err^2 is 2*(WIDTH+1) bits, plus CNT_W bits of growth.
  function automatic int acc_width(input int width, input int cnt_w);
    return 2 * (width + 1) + cnt_w;
  endfunction

endpackage

// File: rtl/approx_err_stage.sv
// Combinational error datapath: exact sum, signed error, |err|, err^2 and nonzero flag.
module approx_err_stage
  import approx_eval_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]       in1,
  input  logic [WIDTH-1:0]       in2,
  input  logic [WIDTH:0]         approx_sum,
  output logic [WIDTH:0]         abs_err,
  output logic [2*(WIDTH+1)-1:0] sq_err,
  output logic                   nonzero
);

  localparam int EW = err_width(WIDTH);
  localparam int SW = 2 * (WIDTH + 1);

  logic [WIDTH:0]        exact;
  logic signed [EW-1:0]  err;

  always_comb begin
    exact = {1'b0, in1} + {1'b0, in2};
    err   = $signed({1'b0, approx_sum}) - $signed({1'b0, exact});
  end

  // Magnitude taken from the unsigned difference in the right direction, so it fits WIDTH+1 bits.
  always_comb begin
    abs_err = err[EW-1] ? (exact - approx_sum) : (approx_sum - exact);
    sq_err  = SW'(abs_err) * SW'(abs_err);
    nonzero = |err;
  end

endmodule

// File: rtl/approx_adder_error_monitor.sv
// Streaming error-statistics monitor for an approximate adder: counts, |err| sum, err^2 sum, max |err|.
module approx_adder_error_monitor
  import approx_eval_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CNT_W     = 16,
  parameter int N_SAMPLES = 1000,
  parameter int ACC_W     = acc_width(WIDTH, CNT_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in1,
  input  logic [WIDTH-1:0]         in2,
  input  logic [WIDTH:0]           approx_sum,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         n_samples,
  output logic [CNT_W-1:0]         n_errors,
  output logic [WIDTH+CNT_W:0]     sum_abs_err,
  output logic [ACC_W-1:0]         sum_sq_err,
  output logic [WIDTH:0]           max_abs_err
);

  localparam int SW  = 2 * (WIDTH + 1);
  localparam int SAW = WIDTH + 1 + CNT_W;

  state_t state;

  logic             transfer, clear, last_accept, pipe_empty;
  logic [CNT_W-1:0] accept_cnt;

  logic             v1, v2, v3;
  logic [WIDTH-1:0] s1_in1, s1_in2;
  logic [WIDTH:0]   s1_sum;

  logic [WIDTH:0]   st_abs;
  logic [SW-1:0]    st_sq;
  logic             st_nz;

  logic [WIDTH:0]   s2_abs;
  logic [SW-1:0]    s2_sq;
  logic             s2_nz;

  logic [CNT_W-1:0] a_cnt, a_err;
  logic [SAW-1:0]   a_abs;
  logic [ACC_W-1:0] a_sq;
  logic [WIDTH:0]   a_max;

  assign in_ready    = (state == RUN);
  assign busy        = (state == RUN) || (state == DRAIN);
  assign done        = (state == DONE);
  assign transfer    = in_valid && in_ready;
  assign clear       = start && ((state == IDLE) || (state == DONE));
  assign last_accept = transfer && (accept_cnt == CNT_W'(N_SAMPLES - 1));
  assign pipe_empty  = !v1 && !v2 && !v3;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (last_accept) state <= DRAIN;
        DRAIN:   if (pipe_empty) state <= DONE;
        DONE:    if (start) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

  approx_err_stage #(.WIDTH(WIDTH)) u_err (
    .in1        (s1_in1),
    .in2        (s1_in2),
    .approx_sum (s1_sum),
    .abs_err    (st_abs),
    .sq_err     (st_sq),
    .nonzero    (st_nz)
  );

  // Accumulators update two edges after acceptance; the result ports are a registered
  // copy one edge later, and v3 keeps DRAIN waiting until that copy has landed.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      accept_cnt  <= '0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      v3          <= 1'b0;
      s1_in1      <= '0;
      s1_in2      <= '0;
      s1_sum      <= '0;
      s2_abs      <= '0;
      s2_sq       <= '0;
      s2_nz       <= 1'b0;
      a_cnt       <= '0;
      a_err       <= '0;
      a_abs       <= '0;
      a_sq        <= '0;
      a_max       <= '0;
      n_samples   <= '0;
      n_errors    <= '0;
      sum_abs_err <= '0;
      sum_sq_err  <= '0;
      max_abs_err <= '0;
    end else begin
      v1 <= transfer;
      v2 <= v1;
      v3 <= v2;
      if (transfer) begin
        accept_cnt <= accept_cnt + CNT_W'(1);
        s1_in1     <= in1;
        s1_in2     <= in2;
        s1_sum     <= approx_sum;
      end
      if (v1) begin
        s2_abs <= st_abs;
        s2_sq  <= st_sq;
        s2_nz  <= st_nz;
      end
      if (v2) begin
        a_cnt <= a_cnt + CNT_W'(1);
        a_err <= a_err + CNT_W'(s2_nz);
        a_abs <= a_abs + SAW'(s2_abs);
        a_sq  <= a_sq + ACC_W'(s2_sq);
        if (s2_abs > a_max) a_max <= s2_abs;
      end
      n_samples   <= a_cnt;
      n_errors    <= a_err;
      sum_abs_err <= a_abs;
      sum_sq_err  <= a_sq;
      max_abs_err <= a_max;
    end
  end

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Directed-vector scoreboard bench for approx_adder_error_monitor (N_SAMPLES=4, WIDTH=16).
module tb_approx_adder_error_monitor;

  localparam int WIDTH = 16;
  localparam int CNT_W = 16;
  localparam int NS    = 4;
  localparam int ACC_W = 2 * (WIDTH + 1) + CNT_W;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [WIDTH-1:0]     in1 = '0;
  logic [WIDTH-1:0]     in2 = '0;
  logic [WIDTH:0]       approx_sum = '0;
  logic                 busy, done;
  logic [CNT_W-1:0]     n_samples, n_errors;
  logic [WIDTH+CNT_W:0] sum_abs_err;
  logic [ACC_W-1:0]     sum_sq_err;
  logic [WIDTH:0]       max_abs_err;

  approx_adder_error_monitor #(
    .WIDTH     (WIDTH),
    .CNT_W     (CNT_W),
    .N_SAMPLES (NS),
    .ACC_W     (ACC_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in1         (in1),
    .in2         (in2),
    .approx_sum  (approx_sum),
    .busy        (busy),
    .done        (done),
    .n_samples   (n_samples),
    .n_errors    (n_errors),
    .sum_abs_err (sum_abs_err),
    .sum_sq_err  (sum_sq_err),
    .max_abs_err (max_abs_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint ns;
    longint ne;
    longint sa;
    longint sq;
    longint mx;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   last_xfer = 0;

  logic [WIDTH-1:0] va[12];
  logic [WIDTH-1:0] vb[12];
  logic [WIDTH:0]   vs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Monitor: compares results each time done rises against the oldest expected run.
  initial begin : monitor
    logic done_q;
    exp_t e;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_q) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("n_samples", 64'(n_samples), 64'(e.ns));
          chk("n_errors", 64'(n_errors), 64'(e.ne));
          chk("sum_abs_err", 64'(sum_abs_err), 64'(e.sa));
          chk("sum_sq_err", 64'(sum_sq_err), 64'(e.sq));
          chk("max_abs_err", 64'(max_abs_err), 64'(e.mx));
          chk("done_latency", 64'(cyc - last_xfer), 4);
        end
      end
      done_q = done;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_range(input int lo, input int hi, input bit toggle);
    for (int i = lo; i <= hi; i++) begin
      if (toggle) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in1        = va[i];
      in2        = vb[i];
      approx_sum = vs[i];
      in_valid   = 1'b1;
      chk("in_ready_offer", 64'(in_ready), 1);
      @(negedge clk);
      last_xfer = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", 64'(done), 1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    exp_t exp1, exp_neg, exp_exact;
    exp1      = '{ns: 4, ne: 2, sa: 11, sq: 101, mx: 10};
    exp_neg   = '{ns: 4, ne: 1, sa: 131070, sq: 64'd17179344900, mx: 131070};
    exp_exact = '{ns: 4, ne: 0, sa: 0, sq: 0, mx: 0};

    va[0] = 3;     vb[0] = 0;     vs[0] = 4;
    va[1] = 0;     vb[1] = 0;     vs[1] = 0;
    va[2] = 255;   vb[2] = 1;     vs[2] = 256;
    va[3] = 100;   vb[3] = 100;   vs[3] = 190;
    va[4] = 65535; vb[4] = 65535; vs[4] = 0;
    va[5] = 1;     vb[5] = 2;     vs[5] = 3;
    va[6] = 0;     vb[6] = 0;     vs[6] = 0;
    va[7] = 10;    vb[7] = 20;    vs[7] = 30;
    for (int i = 8; i < 12; i++) begin
      va[i] = 5; vb[i] = 6; vs[i] = 11;
    end

    // Reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_n_samples", 64'(n_samples), 0);
    chk("rst_n_errors", 64'(n_errors), 0);
    chk("rst_sum_abs", 64'(sum_abs_err), 0);
    chk("rst_sum_sq", 64'(sum_sq_err), 0);
    chk("rst_max_abs", 64'(max_abs_err), 0);

    // Back-to-back run
    sb.push_back(exp1);
    pulse_start();
    chk("run_busy", 64'(busy), 1);
    run_range(0, 3, 1'b0);
    chk("in_ready_drop", 64'(in_ready), 0);
    wait_done();

    // Same vectors with in_valid toggled
    sb.push_back(exp1);
    pulse_start();
    run_range(0, 3, 1'b1);
    chk("in_ready_drop_toggle", 64'(in_ready), 0);
    wait_done();

    // Large negative error
    sb.push_back(exp_neg);
    pulse_start();
    run_range(4, 7, 1'b0);
    wait_done();

    // Restart from DONE, start ignored mid-run
    sb.push_back(exp_exact);
    pulse_start();
    chk("clr_n_samples", 64'(n_samples), 0);
    chk("clr_sum_sq", 64'(sum_sq_err), 0);
    chk("clr_max_abs", 64'(max_abs_err), 0);
    chk("clr_done", 64'(done), 0);
    run_range(8, 9, 1'b0);
    pulse_start();
    repeat (2) @(negedge clk);
    chk("mid_n_samples", 64'(n_samples), 2);
    chk("mid_n_errors", 64'(n_errors), 0);
    chk("mid_sum_sq", 64'(sum_sq_err), 0);
    chk("mid_busy", 64'(busy), 1);
    run_range(10, 11, 1'b0);
    wait_done();

    // Abort with rst after two transfers, then a clean run
    pulse_start();
    run_range(0, 1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", 64'(in_ready), 0);
    chk("abort_busy", 64'(busy), 0);
    chk("abort_done", 64'(done), 0);
    chk("abort_n_samples", 64'(n_samples), 0);
    repeat (5) @(negedge clk);
    chk("abort_flush_n_samples", 64'(n_samples), 0);
    chk("abort_flush_sum_abs", 64'(sum_abs_err), 0);
    chk("abort_flush_busy", 64'(busy), 0);
    sb.push_back(exp1);
    pulse_start();
    run_range(0, 3, 1'b0);
    wait_done();

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
